// File: rtl/fifo_pkg.sv
// Shared FIFO pointer definitions: default geometry and Gray/binary conversion helpers.
package fifo_pkg;

    localparam int ADDRESS_DEF = 3;
    localparam int DEPTH       = 1 << ADDRESS_DEF;
    localparam int PTR_W       = ADDRESS_DEF + 1;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Bits at or above w must be zero on entry; they pass through unchanged.
    function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
        logic [31:0] b;
        b = g;
        for (int i = 30; i >= 0; i--) begin
            if (i < w - 1) b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wptr_wfull_prog_if.sv
// Write-side bundle of the async FIFO: producer request, synchronised read pointer, status outputs.
interface fifo_wptr_wfull_prog_if #(parameter int Address = 3);

    logic               Winc;
    logic [Address:0]   Wq2_rptr;
    logic [Address:0]   Wafull_thr;
    logic               Wovf_clr;
    logic [Address-1:0] Wadder;
    logic [Address:0]   Wptr;
    logic               Wfull;
    logic               Walmost_full;
    logic [Address:0]   Wlevel;
    logic               Wovf;

    modport master (
        output Winc, Wq2_rptr, Wafull_thr, Wovf_clr,
        input  Wadder, Wptr, Wfull, Walmost_full, Wlevel, Wovf
    );

    modport slave (
        input  Winc, Wq2_rptr, Wafull_thr, Wovf_clr,
        output Wadder, Wptr, Wfull, Walmost_full, Wlevel, Wovf
    );

endinterface

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter; each binary bit is the XOR of all Gray bits at or above it.
module fifo_gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    for (genvar i = 0; i < W; i++) begin : g_pfx
        assign bin_o[i] = ^gray_i[W-1:i];
    end

endmodule

// File: rtl/fifo_wptr_wfull_prog.sv
// Write-domain pointer/status block: binary+Gray write pointer, full, level, almost-full, overflow.
// FIFO_WOVF_STICKY_EN: when defined, Wovf is sticky until Wovf_clr; otherwise a per-cycle pulse.
module fifo_wptr_wfull_prog
    import fifo_pkg::*;
#(
    parameter int Address = ADDRESS_DEF
) (
    input logic                   Wclk,
    input logic                   Wrst,
    fifo_wptr_wfull_prog_if.slave wif
);

    localparam int PW = Address + 1;

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q, wgray_d;
    logic [PW-1:0] level_q, level_d;
    logic [PW-1:0] rbin;
    logic          wfull_q, wfull_d;
    logic          wafull_q, wafull_d;
    logic          wovf_q, wovf_d;
    logic          wr_en, ovf_ev;

    fifo_gray2bin #(.W(PW)) u_rptr_g2b (
        .gray_i (wif.Wq2_rptr),
        .bin_o  (rbin)
    );

    // Status is computed from next-state pointers so full asserts on the filling edge.
    always_comb begin
        wr_en    = wif.Winc & ~wfull_q;
        ovf_ev   = wif.Winc & wfull_q;
        wbin_d   = wbin_q + PW'(wr_en);
        wgray_d  = PW'(bin2gray(32'(wbin_d)));
        level_d  = wbin_d - rbin;
        wfull_d  = (wgray_d == {~wif.Wq2_rptr[Address:Address-1], wif.Wq2_rptr[Address-2:0]});
        wafull_d = (level_d >= wif.Wafull_thr);
`ifdef FIFO_WOVF_STICKY_EN
        wovf_d   = ovf_ev | (wovf_q & ~wif.Wovf_clr);
`else
        wovf_d   = ovf_ev;
`endif
    end

`ifndef FIFO_WOVF_STICKY_EN
    logic unused_ovf_clr;
    assign unused_ovf_clr = wif.Wovf_clr;
`endif

    always_ff @(posedge Wclk or negedge Wrst) begin
        if (!Wrst) begin
            wbin_q   <= '0;
            wgray_q  <= '0;
            level_q  <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wgray_q  <= wgray_d;
            level_q  <= level_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wovf_q   <= wovf_d;
        end
    end

    assign wif.Wadder       = wbin_q[Address-1:0];
    assign wif.Wptr         = wgray_q;
    assign wif.Wfull        = wfull_q;
    assign wif.Walmost_full = wafull_q;
    assign wif.Wlevel       = level_q;
    assign wif.Wovf         = wovf_q;

endmodule
